cnn_layer_sched: RTL and testbench

//  Multi-layer frame scheduler in front of cnn_ctrl. Holds a small per-layer geometry table and, on i_run,

---
 rtl/cnn_sched_pkg.sv | 20 ++
 rtl/cnn_layer_tbl.sv | 40 ++++
 rtl/cnn_layer_sched.sv | 178 +++++++++++++++++
 tb/tb_cnn_layer_sched.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_sched_pkg.sv
// cnn_sched_pkg
//   Shared definitions for the multi-layer frame scheduler:
//     - sched_state_e : FSM state encoding (IDLE..DONE)
//     - W_SIZE        : default width/height field width (matches cnn_ctrl)
//     - W_DELAY       : default vsync/hsync delay width
package cnn_sched_pkg;

  localparam int W_SIZE  = 12;
  localparam int W_DELAY = 12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } sched_state_e;

endpackage : cnn_sched_pkg

// File: rtl/cnn_layer_tbl.sv
// cnn_layer_tbl
//   Per-layer geometry table: N_LAYER entries of {width, height}.
//   One synchronous write port and one asynchronous read port.
// Ports
//   clk          in   clock
//   wr_en_i      in   write strobe (already qualified by the caller)
//   wr_addr_i    in   entry to write
//   wr_width_i   in   layer width to store
//   wr_height_i  in   layer height to store
//   rd_addr_i    in   entry to read
//   rd_width_o   out  stored width of rd_addr_i
//   rd_height_o  out  stored height of rd_addr_i
module cnn_layer_tbl #(
  parameter int W_SIZE  = 12,
  parameter int N_LAYER = 4,
  parameter int W_LIDX  = 2
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [W_LIDX-1:0] wr_addr_i,
  input  logic [W_SIZE-1:0] wr_width_i,
  input  logic [W_SIZE-1:0] wr_height_i,
  input  logic [W_LIDX-1:0] rd_addr_i,
  output logic [W_SIZE-1:0] rd_width_o,
  output logic [W_SIZE-1:0] rd_height_o
);

  // NOTE: storage arrays carry no reset; entries are undefined until written,
  // which keeps this a plain register file with no reset fan-out.
  logic [2*W_SIZE-1:0] mem_q [N_LAYER];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= {wr_width_i, wr_height_i};
    end
  end

  assign {rd_width_o, rd_height_o} = mem_q[rd_addr_i];

endmodule : cnn_layer_tbl

// File: rtl/cnn_layer_sched.sv
// cnn_layer_sched
//   Multi-layer frame scheduler in front of cnn_ctrl. On i_run it walks the
//   layer table, loads each layer's geometry onto q_* and pulses q_start for
//   START_LEN cycles, then waits for i_end_frame before moving on. Layers with
//   zero width or height are skipped. o_done pulses once at the end.
// Optional feature
//   CNN_SCHED_TIMEOUT_EN : bounds each WAIT to TIMEOUT_CYC cycles; on expiry
//   o_err is set (sticky until the next i_run) and the sequence is abandoned.
//   Without it WAIT is unbounded and o_err stays 0.
// Ports
//   clk, rst (synchronous, active-high)
//   i_run / i_num_layer          start request and layer count (IDLE only)
//   cfg_we / cfg_addr / cfg_width / cfg_height   table write (idle only)
//   cfg_vsync_delay / cfg_hsync_delay            latched on i_run
//   i_end_frame                  end-of-frame from cnn_ctrl
//   q_width, q_height, q_vsync_delay, q_hsync_delay, q_frame_size, q_start
//                                configuration/start towards cnn_ctrl
//   o_busy, o_layer_idx, o_done, o_err           status
module cnn_layer_sched #(
  parameter int W_SIZE       = cnn_sched_pkg::W_SIZE,
  parameter int W_FRAME_SIZE = 2 * W_SIZE + 1,
  parameter int W_DELAY      = cnn_sched_pkg::W_DELAY,
  parameter int N_LAYER      = 4,
  parameter int START_LEN    = 4,
  parameter int TIMEOUT_CYC  = 1 << 20,
  localparam int W_LIDX      = (N_LAYER > 1) ? $clog2(N_LAYER) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_run,
  input  logic [W_LIDX:0]         i_num_layer,
  input  logic                    cfg_we,
  input  logic [W_LIDX-1:0]       cfg_addr,
  input  logic [W_SIZE-1:0]       cfg_width,
  input  logic [W_SIZE-1:0]       cfg_height,
  input  logic [W_DELAY-1:0]      cfg_vsync_delay,
  input  logic [W_DELAY-1:0]      cfg_hsync_delay,
  input  logic                    i_end_frame,
  output logic [W_SIZE-1:0]       q_width,
  output logic [W_SIZE-1:0]       q_height,
  output logic [W_DELAY-1:0]      q_vsync_delay,
  output logic [W_DELAY-1:0]      q_hsync_delay,
  output logic [W_FRAME_SIZE-1:0] q_frame_size,
  output logic                    q_start,
  output logic                    o_busy,
  output logic [W_LIDX-1:0]       o_layer_idx,
  output logic                    o_done,
  output logic                    o_err
);

  import cnn_sched_pkg::*;

  // One counter serves both the q_start window and the WAIT timeout.
  localparam int CNT_MAX = (TIMEOUT_CYC > START_LEN) ? TIMEOUT_CYC : START_LEN;
  localparam int W_CNT   = $clog2(CNT_MAX + 1);

  sched_state_e      state_q;
  logic [W_LIDX:0]   num_q;
  logic [W_CNT-1:0]  cnt_q;
  logic [W_SIZE-1:0] tbl_width;
  logic [W_SIZE-1:0] tbl_height;
  logic [W_LIDX:0]   num_sat;
  logic [2*W_SIZE-1:0] frame_prod;
  logic              last_layer;

  // The table is frozen while a sequence runs so q_* stay consistent.
  cnn_layer_tbl #(
    .W_SIZE  (W_SIZE),
    .N_LAYER (N_LAYER),
    .W_LIDX  (W_LIDX)
  ) u_tbl (
    .clk         (clk),
    .wr_en_i     (cfg_we && !o_busy),
    .wr_addr_i   (cfg_addr),
    .wr_width_i  (cfg_width),
    .wr_height_i (cfg_height),
    .rd_addr_i   (o_layer_idx),
    .rd_width_o  (tbl_width),
    .rd_height_o (tbl_height)
  );

  assign num_sat    = (i_num_layer > (W_LIDX+1)'(N_LAYER)) ? (W_LIDX+1)'(N_LAYER) : i_num_layer;
  assign frame_prod = {{W_SIZE{1'b0}}, tbl_width} * {{W_SIZE{1'b0}}, tbl_height};
  assign last_layer = ({1'b0, o_layer_idx} == (num_q - (W_LIDX+1)'(1)));

  // NOTE: every register here is assigned with <= so all state updates
  // see the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      num_q         <= '0;
      cnt_q         <= '0;
      q_width       <= '0;
      q_height      <= '0;
      q_vsync_delay <= '0;
      q_hsync_delay <= '0;
      q_frame_size  <= '0;
      q_start       <= 1'b0;
      o_busy        <= 1'b0;
      o_layer_idx   <= '0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_run) begin
            num_q         <= num_sat;
            q_vsync_delay <= cfg_vsync_delay;
            q_hsync_delay <= cfg_hsync_delay;
            o_err         <= 1'b0;
            o_layer_idx   <= '0;
            o_busy        <= 1'b1;
            state_q       <= (num_sat == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          q_width      <= tbl_width;
          q_height     <= tbl_height;
          q_frame_size <= W_FRAME_SIZE'(frame_prod);
          if (tbl_width == '0 || tbl_height == '0) begin
            state_q <= NEXT;
          end else begin
            q_start <= 1'b1;
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == W_CNT'(START_LEN - 1)) begin
            q_start <= 1'b0;
            cnt_q   <= '0;
            state_q <= WAIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT: begin
          if (i_end_frame) begin
            state_q <= NEXT;
          end
`ifdef CNN_SCHED_TIMEOUT_EN
          else if (cnt_q == W_CNT'(TIMEOUT_CYC - 1)) begin
            o_err   <= 1'b1;
            q_start <= 1'b0;
            o_busy  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`else
          else begin
            cnt_q <= '0;
          end
`endif
        end
        NEXT: begin
          if (last_layer) begin
            state_q <= DONE;
          end else begin
            o_layer_idx <= o_layer_idx + 1'b1;
            state_q     <= LOAD;
          end
        end
        DONE: begin
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule : cnn_layer_sched

// File: tb/tb_cnn_layer_sched.sv
// tb_cnn_layer_sched
//   Directed bench for cnn_layer_sched (N_LAYER=4, START_LEN=4,
//   TIMEOUT_CYC=100). Inputs are driven and outputs sampled on the falling
//   edge; the DUT acts on the rising edge.
module tb_cnn_layer_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_run;
  logic [2:0]  i_num_layer;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [11:0] cfg_width;
  logic [11:0] cfg_height;
  logic [11:0] cfg_vsync_delay;
  logic [11:0] cfg_hsync_delay;
  logic        i_end_frame;
  logic [11:0] q_width;
  logic [11:0] q_height;
  logic [11:0] q_vsync_delay;
  logic [11:0] q_hsync_delay;
  logic [24:0] q_frame_size;
  logic        q_start;
  logic        o_busy;
  logic [1:0]  o_layer_idx;
  logic        o_done;
  logic        o_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cnn_layer_sched #(
    .N_LAYER     (4),
    .START_LEN   (4),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_run           (i_run),
    .i_num_layer     (i_num_layer),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_width       (cfg_width),
    .cfg_height      (cfg_height),
    .cfg_vsync_delay (cfg_vsync_delay),
    .cfg_hsync_delay (cfg_hsync_delay),
    .i_end_frame     (i_end_frame),
    .q_width         (q_width),
    .q_height        (q_height),
    .q_vsync_delay   (q_vsync_delay),
    .q_hsync_delay   (q_hsync_delay),
    .q_frame_size    (q_frame_size),
    .q_start         (q_start),
    .o_busy          (o_busy),
    .o_layer_idx     (o_layer_idx),
    .o_done          (o_done),
    .o_err           (o_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then back to the falling edge for drive/sample.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tbl_write(input logic [1:0] a, input logic [11:0] w, input logic [11:0] h);
    cfg_we = 1'b1; cfg_addr = a; cfg_width = w; cfg_height = h;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_run(input logic [2:0] n);
    i_run = 1'b1; i_num_layer = n;
    tick();
    i_run = 1'b0;
  endtask

  // Steps until q_start is seen high; n = edges taken. Bounded.
  task automatic wait_start(input string tag, input int max, output int n);
    n = 0;
    while (!q_start && n < max) begin
      tick();
      n++;
    end
    check(tag, 32'(q_start), 32'd1);
  endtask

  // Counts consecutive high samples of q_start, ending on the first low one.
  task automatic count_start(output int n);
    n = 0;
    while (q_start && n < 16) begin
      n++;
      tick();
    end
  endtask

  // Lets the q_start window close, then pulses i_end_frame for one cycle.
  task automatic end_layer();
    int k = 0;
    while (q_start && k < 16) begin
      tick();
      k++;
    end
    i_end_frame = 1'b1;
    tick();
    i_end_frame = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc, output int starts);
    logic prev;
    prev   = q_start;
    cyc    = 0;
    starts = 0;
    while (!o_done && cyc < max) begin
      tick();
      cyc++;
      if (q_start && !prev) starts++;
      prev = q_start;
    end
  endtask

  initial begin
    int n;
    int cyc;
    int starts;
    int dn;

    rst = 1'b1; i_run = 1'b0; i_num_layer = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_width = '0; cfg_height = '0; cfg_vsync_delay = 12'h123;
    cfg_hsync_delay = 12'h045; i_end_frame = 1'b0;

    // 1: reset
    repeat (4) tick();
    check("rst_busy", 32'(o_busy), 0);
    check("rst_start", 32'(q_start), 0);
    check("rst_frame", 32'(q_frame_size), 0);
    check("rst_width", 32'(q_width), 0);
    check("rst_vdly", 32'(q_vsync_delay), 0);
    check("rst_idx", 32'(o_layer_idx), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_err", 32'(o_err), 0);
    rst = 1'b0;
    tick();

    // 2: two layers, 128x128 then 64x32
    tbl_write(2'd0, 12'd128, 12'd128);
    tbl_write(2'd1, 12'd64, 12'd32);
    start_run(3'd2);
    check("t2_busy", 32'(o_busy), 1);
    check("t2_start_pre", 32'(q_start), 0);
    wait_start("t2_l0_start", 8, n);
    check("t2_l0_lat", 32'(n), 1);
    check("t2_l0_frame", 32'(q_frame_size), 16384);
    check("t2_l0_width", 32'(q_width), 128);
    check("t2_l0_height", 32'(q_height), 128);
    check("t2_vdly", 32'(q_vsync_delay), 12'h123);
    check("t2_hdly", 32'(q_hsync_delay), 12'h045);
    check("t2_l0_idx", 32'(o_layer_idx), 0);
    count_start(n);
    check("t2_l0_startlen", 32'(n), 4);
    i_end_frame = 1'b1;
    tick();
    i_end_frame = 1'b0;
    wait_start("t2_l1_start", 8, n);
    check("t2_l1_lat", 32'(n), 2);
    check("t2_l1_frame", 32'(q_frame_size), 2048);
    check("t2_l1_idx", 32'(o_layer_idx), 1);
    count_start(n);
    check("t2_l1_startlen", 32'(n), 4);
    i_end_frame = 1'b1;
    tick();
    i_end_frame = 1'b0;
    tick();
    check("t2_done_early", 32'(o_done), 0);
    check("t2_busy_done", 32'(o_busy), 1);
    tick();
    check("t2_done", 32'(o_done), 1);
    check("t2_busy_end", 32'(o_busy), 0);
    check("t2_idx_end", 32'(o_layer_idx), 1);
    tick();
    check("t2_done_1cyc", 32'(o_done), 0);

    // 3: zero layers -> o_done two edges after i_run, no q_start
    start_run(3'd0);
    check("t3_done_e1", 32'(o_done), 0);
    check("t3_start_e1", 32'(q_start), 0);
    tick();
    check("t3_done_e2", 32'(o_done), 1);
    check("t3_start_e2", 32'(q_start), 0);
    check("t3_hold_frame", 32'(q_frame_size), 2048);
    tick();

    // 4: skipped zero-width layer, table frozen while busy
    tbl_write(2'd1, 12'd0, 12'd32);
    tbl_write(2'd2, 12'd16, 12'd8);
    start_run(3'd3);
    wait_start("t4_l0_start", 8, n);
    check("t4_l0_frame", 32'(q_frame_size), 16384);
    tbl_write(2'd2, 12'd1, 12'd1);
    end_layer();
    wait_start("t4_l2_start", 8, n);
    check("t4_skip_lat", 32'(n), 4);
    check("t4_l2_idx", 32'(o_layer_idx), 2);
    check("t4_l2_frame", 32'(q_frame_size), 128);
    end_layer();
    wait_done(8, cyc, starts);
    check("t4_done", 32'(o_done), 1);
    check("t4_extra_starts", 32'(starts), 0);
    tick();

    // 5: end_frame ignored in START, reset in WAIT aborts
    start_run(3'd1);
    wait_start("t5_start", 8, n);
    i_end_frame = 1'b1;
    tick();
    i_end_frame = 1'b0;
    check("t5_start2", 32'(q_start), 1);
    tick();
    check("t5_start3", 32'(q_start), 1);
    tick();
    check("t5_start4", 32'(q_start), 1);
    tick();
    check("t5_start_off", 32'(q_start), 0);
    repeat (3) tick();
    check("t5_wait_busy", 32'(o_busy), 1);
    check("t5_wait_nodone", 32'(o_done), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_busy", 32'(o_busy), 0);
    check("t5_rst_frame", 32'(q_frame_size), 0);
    dn = 0;
    repeat (3) begin
      tick();
      dn += int'(o_done);
    end
    check("t5_rst_nodone", 32'(dn), 0);

    // 6: WAIT timeout (or, without the feature, WAIT stays put)
    start_run(3'd1);
    wait_start("t6_start", 8, n);
    repeat (103) tick();
    check("t6_err_before", 32'(o_err), 0);
    check("t6_busy_before", 32'(o_busy), 1);
    tick();
`ifdef CNN_SCHED_TIMEOUT_EN
    check("t6_err", 32'(o_err), 1);
    check("t6_busy", 32'(o_busy), 0);
    check("t6_start", 32'(q_start), 0);
    check("t6_nodone", 32'(o_done), 0);
    start_run(3'd0);
    check("t6_err_clr", 32'(o_err), 0);
    tick();
`else
    check("t6_err_off", 32'(o_err), 0);
    check("t6_busy_on", 32'(o_busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif
    tick();

    // 7: i_num_layer above N_LAYER saturates to 4 (layers 0,2,3 run)
    tbl_write(2'd3, 12'd2, 12'd3);
    start_run(3'd7);
    wait_start("t7_l0_start", 8, n);
    check("t7_l0_frame", 32'(q_frame_size), 16384);
    end_layer();
    wait_start("t7_l2_start", 8, n);
    check("t7_l2_frame", 32'(q_frame_size), 128);
    end_layer();
    wait_start("t7_l3_start", 8, n);
    check("t7_l3_frame", 32'(q_frame_size), 6);
    check("t7_l3_idx", 32'(o_layer_idx), 3);
    end_layer();
    wait_done(8, cyc, starts);
    check("t7_done", 32'(o_done), 1);
    check("t7_done_lat", 32'(cyc), 2);
    check("t7_idx_end", 32'(o_layer_idx), 3);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cnn_layer_sched
